// File: rtl/ifetch_miss_handler.sv
// rtl/ifetch_miss_handler.sv - L1 instruction cache miss handler
//
// Keeps one miss entry per thread. A miss to a line that is already pending
// merges into that entry's waiter bitmap instead of allocating. Entries that
// have not yet been sent to the L2 are issued lowest index first. Each L2
// response walks IDLE -> LRU -> FILL: the LRU cycle asks the tag stage for a
// victim way, the FILL cycle writes tag and data for that way and wakes every
// thread waiting on the line.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ifd_cache_miss, _paddr, _thread_idx miss report from the ifetch data stage
//   l2i_request_valid/_addr/_id         line read request to the L2
//   l2_request_ready                    L2 accepts the request this cycle
//   l2_response_valid/_id/_data         line fill from the L2
//   l2_response_ready                   response consumed this cycle
//   l2i_icache_lru_fill_en/_set         victim way lookup request
//   ift_fill_lru                        victim way, the cycle after the lookup
//   l2i_itag_update_*                   tag array write
//   l2i_idata_update_*                  data array write
//   l2i_icache_wake_bitmap              threads released this cycle

module ifetch_miss_handler #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WAYS    = 4,
  parameter int SET_BITS    = 6,
  localparam int TID_W      = $clog2(NUM_THREADS),
  localparam int WAY_W      = $clog2(NUM_WAYS),
  localparam int TAG_BITS   = 26 - SET_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifd_cache_miss,
  input  logic [25:0]            ifd_cache_miss_paddr,
  input  logic [TID_W-1:0]       ifd_cache_miss_thread_idx,
  output logic                   l2i_request_valid,
  output logic [25:0]            l2i_request_addr,
  output logic [TID_W-1:0]       l2i_request_id,
  input  logic                   l2_request_ready,
  input  logic                   l2_response_valid,
  input  logic [TID_W-1:0]       l2_response_id,
  input  logic [511:0]           l2_response_data,
  output logic                   l2_response_ready,
  output logic                   l2i_icache_lru_fill_en,
  output logic [SET_BITS-1:0]    l2i_icache_lru_fill_set,
  input  logic [WAY_W-1:0]       ift_fill_lru,
  output logic [NUM_WAYS-1:0]    l2i_itag_update_en,
  output logic [SET_BITS-1:0]    l2i_itag_update_set,
  output logic [TAG_BITS-1:0]    l2i_itag_update_tag,
  output logic                   l2i_itag_update_valid,
  output logic                   l2i_idata_update_en,
  output logic [WAY_W-1:0]       l2i_idata_update_way,
  output logic [SET_BITS-1:0]    l2i_idata_update_set,
  output logic [511:0]           l2i_idata_update_data,
  output logic [NUM_THREADS-1:0] l2i_icache_wake_bitmap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LRU  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t state;

  // Miss entries, indexed by the thread that allocated them.
  logic [NUM_THREADS-1:0] ent_valid;
  logic [NUM_THREADS-1:0] ent_issued;
  logic [25:0]            ent_addr    [NUM_THREADS];
  logic [NUM_THREADS-1:0] ent_waiters [NUM_THREADS];

  // Response being filled.
  logic [TID_W-1:0] fill_id;
  logic [511:0]     fill_data;
  logic [25:0]      fill_addr;
  logic             in_fill;

  logic [NUM_THREADS-1:0] miss_onehot;
  logic [NUM_THREADS-1:0] entry_hit;
  logic                   fill_hit;
  logic                   req_found;
  logic [TID_W-1:0]       req_idx;

  // The filling entry stays valid until the end of FILL, so its address is
  // read straight from the entry rather than copied.
  assign fill_addr = ent_addr[fill_id];
  assign in_fill   = (state == S_FILL);

  always_comb begin
    miss_onehot = '0;
    miss_onehot[ifd_cache_miss_thread_idx] = 1'b1;
  end

  always_comb begin
    entry_hit = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      entry_hit[i] = ent_valid[i] && (ent_addr[i] == ifd_cache_miss_paddr);
    end
  end

  // A miss to the line being written this cycle is woken directly; it would
  // otherwise merge into an entry that is being freed.
  assign fill_hit = in_fill && ifd_cache_miss && (ifd_cache_miss_paddr == fill_addr);

  // Lowest-index entry waiting to be issued; scan downward so the lowest wins.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (ent_valid[i] && !ent_issued[i]) begin
        req_found = 1'b1;
        req_idx   = TID_W'(i);
      end
    end
  end

  assign l2i_request_valid = req_found;
  assign l2i_request_addr  = req_found ? ent_addr[req_idx] : '0;
  assign l2i_request_id    = req_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid  <= '0;
      ent_issued <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        ent_addr[i]    <= '0;
        ent_waiters[i] <= '0;
      end
    end else begin
      if (req_found && l2_request_ready) begin
        ent_issued[req_idx] <= 1'b1;
      end
      if (in_fill) begin
        ent_valid[fill_id] <= 1'b0;
      end
      if (ifd_cache_miss && !fill_hit) begin
        if (|entry_hit) begin
          for (int i = 0; i < NUM_THREADS; i++) begin
            if (entry_hit[i]) begin
              ent_waiters[i] <= ent_waiters[i] | miss_onehot;
            end
          end
        end else begin
          ent_valid[ifd_cache_miss_thread_idx]   <= 1'b1;
          ent_issued[ifd_cache_miss_thread_idx]  <= 1'b0;
          ent_addr[ifd_cache_miss_thread_idx]    <= ifd_cache_miss_paddr;
          ent_waiters[ifd_cache_miss_thread_idx] <= miss_onehot;
        end
      end
    end
  end

  // Fill sequencer. Responses for invalid entries are consumed in IDLE and
  // dropped, which also covers responses left over from before a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      l2_response_ready       <= 1'b1;
      l2i_icache_lru_fill_en  <= 1'b0;
      l2i_icache_lru_fill_set <= '0;
      fill_id                 <= '0;
      fill_data               <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l2_response_valid && ent_valid[l2_response_id]) begin
            fill_id                 <= l2_response_id;
            fill_data               <= l2_response_data;
            l2_response_ready       <= 1'b0;
            l2i_icache_lru_fill_en  <= 1'b1;
            l2i_icache_lru_fill_set <= ent_addr[l2_response_id][SET_BITS-1:0];
            state                   <= S_LRU;
          end
        end
        S_LRU: begin
          l2i_icache_lru_fill_en  <= 1'b0;
          l2i_icache_lru_fill_set <= '0;
          state                   <= S_FILL;
        end
        S_FILL: begin
          l2_response_ready <= 1'b1;
          state             <= S_IDLE;
        end
        default: begin
          l2_response_ready       <= 1'b1;
          l2i_icache_lru_fill_en  <= 1'b0;
          l2i_icache_lru_fill_set <= '0;
          state                   <= S_IDLE;
        end
      endcase
    end
  end

  // The victim way arrives from the tag stage during FILL, so the array
  // writes are driven combinationally in that cycle.
  always_comb begin
    l2i_itag_update_en = '0;
    if (in_fill) begin
      l2i_itag_update_en[ift_fill_lru] = 1'b1;
    end
  end

  assign l2i_itag_update_set    = in_fill ? fill_addr[SET_BITS-1:0] : '0;
  assign l2i_itag_update_tag    = in_fill ? fill_addr[25:SET_BITS] : '0;
  assign l2i_itag_update_valid  = in_fill;
  assign l2i_idata_update_en    = in_fill;
  assign l2i_idata_update_way   = in_fill ? ift_fill_lru : '0;
  assign l2i_idata_update_set   = in_fill ? fill_addr[SET_BITS-1:0] : '0;
  assign l2i_idata_update_data  = in_fill ? fill_data : '0;
  assign l2i_icache_wake_bitmap = in_fill ? (ent_waiters[fill_id] | (fill_hit ? miss_onehot : '0)) : '0;

endmodule

// File: tb/tb_ifetch_miss_handler.sv
// tb/tb_ifetch_miss_handler.sv - scoreboard bench for ifetch_miss_handler
module tb_ifetch_miss_handler;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         ifd_cache_miss;
  logic [25:0]  ifd_cache_miss_paddr;
  logic [1:0]   ifd_cache_miss_thread_idx;
  logic         l2i_request_valid;
  logic [25:0]  l2i_request_addr;
  logic [1:0]   l2i_request_id;
  logic         l2_request_ready;
  logic         l2_response_valid;
  logic [1:0]   l2_response_id;
  logic [511:0] l2_response_data;
  logic         l2_response_ready;
  logic         l2i_icache_lru_fill_en;
  logic [5:0]   l2i_icache_lru_fill_set;
  logic [1:0]   ift_fill_lru;
  logic [3:0]   l2i_itag_update_en;
  logic [5:0]   l2i_itag_update_set;
  logic [19:0]  l2i_itag_update_tag;
  logic         l2i_itag_update_valid;
  logic         l2i_idata_update_en;
  logic [1:0]   l2i_idata_update_way;
  logic [5:0]   l2i_idata_update_set;
  logic [511:0] l2i_idata_update_data;
  logic [3:0]   l2i_icache_wake_bitmap;

  ifetch_miss_handler dut (
    .clk                       (clk),
    .reset                     (reset),
    .ifd_cache_miss            (ifd_cache_miss),
    .ifd_cache_miss_paddr      (ifd_cache_miss_paddr),
    .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
    .l2i_request_valid         (l2i_request_valid),
    .l2i_request_addr          (l2i_request_addr),
    .l2i_request_id            (l2i_request_id),
    .l2_request_ready          (l2_request_ready),
    .l2_response_valid         (l2_response_valid),
    .l2_response_id            (l2_response_id),
    .l2_response_data          (l2_response_data),
    .l2_response_ready         (l2_response_ready),
    .l2i_icache_lru_fill_en    (l2i_icache_lru_fill_en),
    .l2i_icache_lru_fill_set   (l2i_icache_lru_fill_set),
    .ift_fill_lru              (ift_fill_lru),
    .l2i_itag_update_en        (l2i_itag_update_en),
    .l2i_itag_update_set       (l2i_itag_update_set),
    .l2i_itag_update_tag       (l2i_itag_update_tag),
    .l2i_itag_update_valid     (l2i_itag_update_valid),
    .l2i_idata_update_en       (l2i_idata_update_en),
    .l2i_idata_update_way      (l2i_idata_update_way),
    .l2i_idata_update_set      (l2i_idata_update_set),
    .l2i_idata_update_data     (l2i_idata_update_data),
    .l2i_icache_wake_bitmap    (l2i_icache_wake_bitmap)
  );

  typedef struct {
    logic [1:0]  id;
    logic [25:0] line;
  } req_t;

  typedef struct {
    logic [1:0]   id;
    logic [25:0]  line;
    logic [511:0] data;
  } fill_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit mon_en     = 1'b0;
  bit resp_taken = 1'b0;
  int fill_busy  = 0;

  // Reference model: pending lines per miss entry, with their waiting threads.
  bit          m_live   [4];
  bit          m_issued [4];
  logic [25:0] m_line   [4];
  logic [3:0]  m_wait   [4];
  int          m_alloc  [4];
  bit          busy     [4];

  req_t  l2q[$];
  fill_t fillq[$];

  int          mon_e;
  fill_t       mon_f;
  req_t        mon_r;
  logic [3:0]  exp_en;
  logic [25:0] pool [6];
  int          k;
  int          t;
  int          n_hold;
  int          w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [3:0] busy_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = busy[i];
    return m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_live[i]   = 1'b0;
      m_issued[i] = 1'b0;
      m_wait[i]   = '0;
      busy[i]     = 1'b0;
    end
    l2q.delete();
    fillq.delete();
    fill_busy = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ifd_cache_miss = 1'b0;
  endtask

  // Drive a miss this cycle and record it: merge into a pending line or
  // open a new entry owned by the missing thread.
  task automatic do_miss(input int th, input logic [25:0] line);
    bit merged = 1'b0;
    ifd_cache_miss            = 1'b1;
    ifd_cache_miss_paddr      = line;
    ifd_cache_miss_thread_idx = th[1:0];
    busy[th] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!merged && m_live[i] && m_line[i] == line) begin
        m_wait[i] = m_wait[i] | (4'b0001 << th);
        merged    = 1'b1;
      end
    end
    if (!merged) begin
      m_live[th]   = 1'b1;
      m_issued[th] = 1'b0;
      m_line[th]   = line;
      m_wait[th]   = 4'b0001 << th;
      m_alloc[th]  = cyc;
    end
  endtask

  task automatic wait_l2q(input int n);
    int cnt = 0;
    while (l2q.size() < n && cnt < 50) begin
      tick();
      cnt++;
    end
    check("wait_l2q", 512'(l2q.size() >= n), 512'(1));
  endtask

  // Present a response, hold it until taken; returns at the start of the
  // cycle after acceptance with valid dropped.
  task automatic send_resp(input logic [1:0] id, output int n);
    n = 0;
    l2_response_valid = 1'b1;
    l2_response_id    = id;
    l2_response_data  = rand512();
    resp_taken        = 1'b0;
    while (!resp_taken && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("resp_taken", 512'(resp_taken), 512'(1));
    tick();
    l2_response_valid = 1'b0;
    resp_taken        = 1'b0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_e = -1;
      for (int i = 3; i >= 0; i--) begin
        if (m_live[i] && !m_issued[i] && m_alloc[i] < cyc) mon_e = i;
      end
      check("req_valid", 512'(l2i_request_valid), 512'(mon_e >= 0));
      if (mon_e >= 0 && l2i_request_valid) begin
        check("req_addr", 512'(l2i_request_addr), 512'(m_line[mon_e]));
        check("req_id", 512'(l2i_request_id), 512'(mon_e));
        if (l2_request_ready) begin
          m_issued[mon_e] = 1'b1;
          mon_r.id   = mon_e[1:0];
          mon_r.line = m_line[mon_e];
          l2q.push_back(mon_r);
        end
      end

      check("resp_ready", 512'(l2_response_ready), 512'(fill_busy == 0));
      check("lru_en", 512'(l2i_icache_lru_fill_en), 512'(fill_busy == 2));
      if (fill_busy == 2 && fillq.size() > 0)
        check("lru_set", 512'(l2i_icache_lru_fill_set), 512'(fillq[0].line[5:0]));

      check("fill_timing",
            512'((|l2i_itag_update_en) | l2i_idata_update_en | (|l2i_icache_wake_bitmap) | l2i_itag_update_valid),
            512'(fill_busy == 1));

      if (|l2i_itag_update_en) begin
        if (fillq.size() == 0) begin
          check("fill_unexpected", 512'(l2i_itag_update_en), 512'(0));
        end else begin
          mon_f  = fillq.pop_front();
          exp_en = 4'b0001 << ift_fill_lru;
          check("tag_en", 512'(l2i_itag_update_en), 512'(exp_en));
          check("tag_set", 512'(l2i_itag_update_set), 512'(mon_f.line[5:0]));
          check("tag_val", 512'(l2i_itag_update_tag), 512'(mon_f.line[25:6]));
          check("tag_valid", 512'(l2i_itag_update_valid), 512'(1));
          check("data_en", 512'(l2i_idata_update_en), 512'(1));
          check("data_way", 512'(l2i_idata_update_way), 512'(ift_fill_lru));
          check("data_set", 512'(l2i_idata_update_set), 512'(mon_f.line[5:0]));
          check("data", l2i_idata_update_data, mon_f.data);
          check("wake", 512'(l2i_icache_wake_bitmap), 512'(m_wait[mon_f.id]));
          for (int j = 0; j < 4; j++) if (m_wait[mon_f.id][j]) busy[j] = 1'b0;
          m_live[mon_f.id] = 1'b0;
          m_wait[mon_f.id] = '0;
        end
      end

      if (l2_response_valid && fill_busy == 0 && !resp_taken) begin
        resp_taken = 1'b1;
        if (m_live[l2_response_id]) begin
          mon_f.id   = l2_response_id;
          mon_f.line = m_line[l2_response_id];
          mon_f.data = l2_response_data;
          fillq.push_back(mon_f);
          fill_busy = 3;
        end
      end

      if (fill_busy > 0) fill_busy--;
      if (reset) model_reset();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                     = 1'b1;
    ifd_cache_miss            = 1'b0;
    ifd_cache_miss_paddr      = '0;
    ifd_cache_miss_thread_idx = '0;
    l2_request_ready          = 1'b1;
    l2_response_valid         = 1'b0;
    l2_response_id            = '0;
    l2_response_data          = '0;
    ift_fill_lru              = 2'd2;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_valid", 512'(l2i_request_valid), 512'(0));
    check("rst_resp_ready", 512'(l2_response_ready), 512'(1));
    check("rst_outputs",
          512'({l2i_icache_lru_fill_en, l2i_itag_update_en, l2i_itag_update_valid,
                l2i_idata_update_en, l2i_icache_wake_bitmap}), 512'(0));
    mon_en = 1'b1;

    // Single miss, request latency, fill to way 2.
    tick();
    do_miss(0, 26'h0000040);
    @(negedge clk);
    check("t1_no_req_yet", 512'(l2i_request_valid), 512'(0));
    tick();
    @(negedge clk);
    check("t1_req_valid", 512'(l2i_request_valid), 512'(1));
    check("t1_req_addr", 512'(l2i_request_addr), 512'(26'h40));
    check("t1_req_id", 512'(l2i_request_id), 512'(0));
    tick();
    send_resp(2'd0, n_hold);
    @(negedge clk);
    check("t1_lru_en", 512'(l2i_icache_lru_fill_en), 512'(1));
    check("t1_lru_set", 512'(l2i_icache_lru_fill_set), 512'(0));
    @(negedge clk);
    check("t1_tag_en", 512'(l2i_itag_update_en), 512'(4'b0100));
    check("t1_tag", 512'(l2i_itag_update_tag), 512'(20'h1));
    check("t1_wake", 512'(l2i_icache_wake_bitmap), 512'(4'b0001));
    tick();
    l2q.delete();

    // Two threads on one line: a single request, both woken.
    l2_request_ready = 1'b0;
    do_miss(1, 26'h0001234);
    tick();
    do_miss(3, 26'h0001234);
    tick();
    tick();
    l2_request_ready = 1'b1;
    wait_l2q(1);
    repeat (3) tick();
    check("t2_one_req", 512'(l2q.size()), 512'(1));
    send_resp(2'd1, n_hold);
    @(negedge clk);
    @(negedge clk);
    check("t2_wake", 512'(l2i_icache_wake_bitmap), 512'(4'b1010));
    tick();
    l2q.delete();

    // Four distinct lines held back, then issued in id order; back-to-back fills.
    l2_request_ready = 1'b0;
    do_miss(0, 26'h0000100); tick();
    do_miss(1, 26'h0001140); tick();
    do_miss(2, 26'h2000FC0); tick();
    do_miss(3, 26'h3FFFFFF); tick();
    repeat (5) tick();
    l2_request_ready = 1'b1;
    wait_l2q(4);
    for (int i = 0; i < 4; i++) check("t3_order", 512'(l2q[i].id), 512'(i));
    ift_fill_lru = 2'd1;
    send_resp(2'd1, n_hold);
    ift_fill_lru = 2'd3;
    send_resp(2'd2, n_hold);
    check("t6_hold", 512'(n_hold), 512'(3));
    send_resp(2'd0, n_hold);
    send_resp(2'd3, n_hold);
    repeat (3) tick();
    check("t3_all_woken", 512'(busy_mask()), 512'(0));
    l2q.delete();

    // Same-line miss during the FILL cycle is woken with no new entry.
    ift_fill_lru = 2'd0;
    do_miss(0, 26'h00ABCDE);
    tick();
    wait_l2q(1);
    send_resp(2'd0, n_hold);
    tick();
    do_miss(2, 26'h00ABCDE);
    @(negedge clk);
    check("t4_wake", 512'(l2i_icache_wake_bitmap), 512'(4'b0101));
    repeat (3) tick();
    check("t4_no_new_req", 512'(l2q.size()), 512'(1));
    l2q.delete();

    // Reset during LRU, then a stale response is dropped.
    do_miss(1, 26'h0000099);
    tick();
    wait_l2q(1);
    send_resp(2'd1, n_hold);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_req_valid", 512'(l2i_request_valid), 512'(0));
    check("t5_resp_ready", 512'(l2_response_ready), 512'(1));
    check("t5_outputs",
          512'({l2i_icache_lru_fill_en, l2i_icache_lru_fill_set, l2i_itag_update_en,
                l2i_itag_update_valid, l2i_idata_update_en, l2i_icache_wake_bitmap}), 512'(0));
    tick();
    send_resp(2'd1, n_hold);
    check("t5_stale_taken_at_once", 512'(n_hold), 512'(1));
    repeat (3) tick();

    // Randomized traffic with a small line pool to force merges.
    for (int i = 0; i < 6; i++) pool[i] = 26'($urandom);
    pool[5] = pool[0] ^ 26'h0000040;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (l2_response_valid && resp_taken) begin
        l2_response_valid = 1'b0;
        resp_taken        = 1'b0;
      end
      if (!l2_response_valid && l2q.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, l2q.size() - 1);
        l2_response_id    = l2q[k].id;
        l2_response_data  = rand512();
        l2_response_valid = 1'b1;
        l2q.delete(k);
      end
      if (c < 2700 && $urandom_range(0, 1) == 0) begin
        t = $urandom_range(0, 3);
        if (!busy[t]) do_miss(t, pool[$urandom_range(0, 5)]);
      end
      l2_request_ready = ($urandom_range(0, 3) != 0);
      ift_fill_lru     = 2'($urandom_range(0, 3));
    end
    l2_request_ready = 1'b1;
    w = 0;
    while ((busy_mask() != 0 || l2q.size() > 0 || l2_response_valid) && w < 500) begin
      tick();
      if (l2_response_valid && resp_taken) begin
        l2_response_valid = 1'b0;
        resp_taken        = 1'b0;
      end
      if (!l2_response_valid && l2q.size() > 0) begin
        l2_response_id    = l2q[0].id;
        l2_response_data  = rand512();
        l2_response_valid = 1'b1;
        l2q.delete(0);
      end
      w++;
    end
    repeat (4) tick();
    check("drain_busy", 512'(busy_mask()), 512'(0));
    check("drain_fills", 512'(fillq.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
